stack_access_ctrl: RTL and testbench

//  Client side of the StackPointer interface: sequences PUSH/POP/PEEK/SWAP requests from the

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_ram.sv | 26 ++
 rtl/stack_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_stack_access_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack access controller: request op codes and FSM state encoding.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_PEEK_RD,
    ST_RD_RSP,
    ST_SW_RA,
    ST_SW_RB,
    ST_SW_WA,
    ST_SW_WB
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read with one cycle of latency.
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Read returns the pre-write contents when the same address is written.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/stack_access_ctrl.sv
// Client side of the StackPointer interface: sequences PUSH/POP/PEEK/SWAP, owns the stack RAM,
// tracks occupancy and raises sticky overflow/underflow flags.
module stack_access_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          I_SP,
  output logic          D_SP,
  output logic [AW-1:0] SP_load_data,
  input  logic [AW-1:0] SP_address,
  output logic          ovf,
  output logic          unf,
  input  logic          err_clr
);

  localparam int unsigned CW = AW + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic [DW-1:0] data_q;
  logic [DW-1:0] swap_b;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  assign SP_load_data = '0;

  // RAM port steering; SP_address already reads SP-1 while D_SP is asserted.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = SP_address;
    ram_wdata = data_q;
    case (state)
      ST_PUSH_WR: ram_we = 1'b1;
      ST_PEEK_RD,
      ST_SW_RA:   ram_addr = SP_address - AW'(1);
      ST_SW_RB:   ram_addr = SP_address - AW'(2);
      ST_SW_WA: begin
        ram_we   = 1'b1;
        ram_addr = SP_address - AW'(2);
      end
      ST_SW_WB: begin
        ram_we    = 1'b1;
        ram_addr  = SP_address - AW'(1);
        ram_wdata = swap_b;
      end
      default: ;
    endcase
  end

  stack_ram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Sequencer; pointer controls are registered alongside the state they belong to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_INIT;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      op_ready <= 1'b0;
      I_SP     <= 1'b1;
      D_SP     <= 1'b1;
      data_q   <= '0;
      swap_b   <= '0;
    end else begin
      rd_valid <= 1'b0;
      I_SP     <= 1'b0;
      D_SP     <= 1'b0;
      ovf      <= ovf & ~err_clr;
      unf      <= unf & ~err_clr;
      case (state)
        ST_INIT: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
        ST_IDLE: begin
          if (op_valid) begin
            data_q <= wr_data;
            case (op_code)
              OP_PUSH: begin
                if (count == CW'(DEPTH)) begin
                  ovf <= 1'b1;
                end else begin
                  state    <= ST_PUSH_WR;
                  op_ready <= 1'b0;
                  I_SP     <= 1'b1;
                end
              end
              OP_POP: begin
                if (count == '0) begin
                  unf <= 1'b1;
                end else begin
                  state    <= ST_POP_RD;
                  op_ready <= 1'b0;
                  D_SP     <= 1'b1;
                end
              end
              OP_PEEK: begin
                if (count == '0) begin
                  unf <= 1'b1;
                end else begin
                  state    <= ST_PEEK_RD;
                  op_ready <= 1'b0;
                end
              end
              OP_SWAP: begin
                if (count < CW'(2)) begin
                  unf <= 1'b1;
                end else begin
                  state    <= ST_SW_RA;
                  op_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_PUSH_WR: begin
          count    <= count + CW'(1);
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
        ST_POP_RD: begin
          count <= count - CW'(1);
          state <= ST_RD_RSP;
        end
        ST_PEEK_RD: state <= ST_RD_RSP;
        ST_RD_RSP: begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
        ST_SW_RA: state <= ST_SW_RB;
        ST_SW_RB: begin
          data_q <= ram_q;
          state  <= ST_SW_WA;
        end
        ST_SW_WA: begin
          swap_b <= ram_q;
          state  <= ST_SW_WB;
        end
        ST_SW_WB: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Self-checking bench: behavioural StackPointer plus stack_access_ctrl, directed vector table
// and hand-written sequences for fill/overflow and reset during a swap.
module tb_stack_access_ctrl;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] PEEK = 2'b10;
  localparam logic [1:0] SWAP = 2'b11;

  logic       CLK;
  logic       RST;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       I_SP;
  logic       D_SP;
  logic [7:0] SP_load_data;
  logic [7:0] SP_address;
  logic       ovf;
  logic       unf;
  logic       err_clr;

  logic [7:0] sp;
  int         total = 0;
  int         bad = 0;
  int         rv_total = 0;

  stack_access_ctrl #(.DW(8), .AW(8), .DEPTH(256)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_ready     (op_ready),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .I_SP         (I_SP),
    .D_SP         (D_SP),
    .SP_load_data (SP_load_data),
    .SP_address   (SP_address),
    .ovf          (ovf),
    .unf          (unf),
    .err_clr      (err_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // StackPointer model: load on I&D, else increment/decrement; address is SP-1 while decrementing.
  always @(posedge CLK) begin
    if (I_SP && D_SP)  sp <= SP_load_data;
    else if (I_SP)     sp <= sp + 8'd1;
    else if (D_SP)     sp <= sp - 8'd1;
  end
  assign SP_address = D_SP ? sp - 8'd1 : sp;

  always @(negedge CLK) begin
    if (rd_valid === 1'b1) rv_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one request at a falling edge; cycle c counts from the accept cycle (0).
  task automatic do_op(input logic [1:0] op, input logic [7:0] d,
                       output int lat, output int rv_cnt, output int rv_cyc, output int isp_cnt);
    lat = 0; rv_cnt = 0; rv_cyc = 0; isp_cnt = 0;
    op_valid = 1'b1;
    op_code  = op;
    wr_data  = d;
    @(posedge CLK);
    @(negedge CLK);
    op_valid = 1'b0;
    err_clr  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (rd_valid === 1'b1) begin
        rv_cnt++;
        rv_cyc = c;
      end
      if (I_SP === 1'b1) isp_cnt++;
      if (op_ready === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic       clr;
    logic [1:0] op;
    logic [7:0] d;
    int         lat;
    int         rv;
    int         isp;
    logic [7:0] rd;
    logic [7:0] sp;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t v[17];

  initial begin
    int lat, rvn, rvc, ispn, errs, rv_before;

    v[0]  = '{1'b0, PUSH, 8'hA5, 2, 0, 1, 8'h00, 8'd1, 1'b0, 1'b0};
    v[1]  = '{1'b0, PUSH, 8'h3C, 2, 0, 1, 8'h00, 8'd2, 1'b0, 1'b0};
    v[2]  = '{1'b0, POP,  8'h00, 3, 1, 0, 8'h3C, 8'd1, 1'b0, 1'b0};
    v[3]  = '{1'b0, POP,  8'h00, 3, 1, 0, 8'hA5, 8'd0, 1'b0, 1'b0};
    v[4]  = '{1'b0, POP,  8'h00, 1, 0, 0, 8'hA5, 8'd0, 1'b0, 1'b1};
    v[5]  = '{1'b1, PUSH, 8'h00, 0, 0, 0, 8'hA5, 8'd0, 1'b0, 1'b0};
    v[6]  = '{1'b0, PUSH, 8'h11, 2, 0, 1, 8'hA5, 8'd1, 1'b0, 1'b0};
    v[7]  = '{1'b0, PUSH, 8'h22, 2, 0, 1, 8'hA5, 8'd2, 1'b0, 1'b0};
    v[8]  = '{1'b0, SWAP, 8'h00, 5, 0, 0, 8'hA5, 8'd2, 1'b0, 1'b0};
    v[9]  = '{1'b0, PEEK, 8'h00, 3, 1, 0, 8'h11, 8'd2, 1'b0, 1'b0};
    v[10] = '{1'b0, POP,  8'h00, 3, 1, 0, 8'h11, 8'd1, 1'b0, 1'b0};
    v[11] = '{1'b0, POP,  8'h00, 3, 1, 0, 8'h22, 8'd0, 1'b0, 1'b0};
    v[12] = '{1'b0, PUSH, 8'h33, 2, 0, 1, 8'h22, 8'd1, 1'b0, 1'b0};
    v[13] = '{1'b0, SWAP, 8'h00, 1, 0, 0, 8'h22, 8'd1, 1'b0, 1'b1};
    v[14] = '{1'b1, PUSH, 8'h00, 0, 0, 0, 8'h22, 8'd1, 1'b0, 1'b0};
    v[15] = '{1'b0, PEEK, 8'h00, 3, 1, 0, 8'h33, 8'd1, 1'b0, 1'b0};
    v[16] = '{1'b0, POP,  8'h00, 3, 1, 0, 8'h33, 8'd0, 1'b0, 1'b0};

    // Reset state and pointer resynchronisation.
    RST = 1'b1; op_valid = 1'b0; op_code = 2'b00; wr_data = 8'h00; err_clr = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_isp", I_SP, 1);
    chk("rst_dsp", D_SP, 1);
    chk("rst_ready", op_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("load_data", SP_load_data, 0);
    RST = 1'b0;
    #1;
    chk("init_isp", I_SP, 1);
    chk("init_dsp", D_SP, 1);
    @(negedge CLK);
    chk("idle_ready", op_ready, 1);
    chk("idle_isp", I_SP, 0);
    chk("idle_dsp", D_SP, 0);
    chk("idle_sp", sp, 0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      if (v[i].clr) begin
        do_clr();
      end else begin
        do_op(v[i].op, v[i].d, lat, rvn, rvc, ispn);
        chk($sformatf("v%0d_lat", i), lat, v[i].lat);
        chk($sformatf("v%0d_rv_cnt", i), rvn, v[i].rv);
        chk($sformatf("v%0d_rv_cyc", i), rvc, (v[i].rv != 0) ? v[i].lat : 0);
        chk($sformatf("v%0d_isp", i), ispn, v[i].isp);
      end
      chk($sformatf("v%0d_rd_data", i), rd_data, v[i].rd);
      chk($sformatf("v%0d_sp", i), sp, v[i].sp);
      chk($sformatf("v%0d_ovf", i), ovf, v[i].ovf);
      chk($sformatf("v%0d_unf", i), unf, v[i].unf);
    end

    // Fill to DEPTH, overflow, error-clear priority, then pop the top entry.
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      do_op(PUSH, 8'(i), lat, rvn, rvc, ispn);
      if (lat != 2 || ispn != 1) errs++;
    end
    chk("fill_errs", errs, 0);
    chk("fill_sp_wrap", sp, 0);
    chk("fill_ovf", ovf, 0);
    do_op(PUSH, 8'hEE, lat, rvn, rvc, ispn);
    chk("full_lat", lat, 1);
    chk("full_isp", ispn, 0);
    chk("full_ovf", ovf, 1);
    chk("full_sp", sp, 0);
    err_clr = 1'b1;
    do_op(PUSH, 8'hEE, lat, rvn, rvc, ispn);
    chk("clr_vs_set_ovf", ovf, 1);
    do_clr();
    chk("clr_ovf", ovf, 0);
    do_op(POP, 8'h00, lat, rvn, rvc, ispn);
    chk("full_pop_lat", lat, 3);
    chk("full_pop_data", rd_data, 8'hFF);
    chk("full_pop_sp", sp, 8'hFF);

    // Reset during the first swap write abandons the op.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    do_op(PUSH, 8'h44, lat, rvn, rvc, ispn);
    do_op(PUSH, 8'h55, lat, rvn, rvc, ispn);
    chk("sw_pre_sp", sp, 2);
    rv_before = rv_total;
    op_valid = 1'b1;
    op_code  = SWAP;
    @(posedge CLK);
    @(negedge CLK);
    op_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_ready", op_ready, 0);
    chk("abort_isp", I_SP, 1);
    chk("abort_dsp", D_SP, 1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_sp", sp, 0);
    chk("abort_ready_back", op_ready, 1);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_no_rv", rv_total, rv_before);
    do_op(PEEK, 8'h00, lat, rvn, rvc, ispn);
    chk("abort_peek_lat", lat, 1);
    chk("abort_peek_rv", rvn, 0);
    chk("abort_peek_unf", unf, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
